// File: rtl/next_pc_gen_pkg.sv
// npc_pkg: shared prediction types and fetch constants for the next-PC generator
package npc_pkg;
    typedef enum logic [1:0] {SRC_SEQ, SRC_BTB, SRC_RAS, SRC_ID} pred_src_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_next;
        pred_src_t   src;
    } pred_entry_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/next_pc_gen_if.sv
// next_pc_gen_if: front-end prediction/resolve bus; stat ports exist only with NPC_STATS_EN
interface next_pc_gen_if;
    logic        stall;
    logic        is_ctrl_IF;
    logic        ras_hit;
    logic [31:0] ras_pc;
    logic        btb_hit;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic        id_redirect;
    logic [31:0] id_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic [31:0] PC_IF;
    logic        flush;
    logic        fifo_full;
    logic        resolve_err;
`ifdef NPC_STATS_EN
    logic [31:0] stat_pred;
    logic [31:0] stat_mispred;
`endif
    modport master (
        output stall, is_ctrl_IF, ras_hit, ras_pc, btb_hit, btb_taken, btb_target,
        output id_redirect, id_target, resolve_valid, resolve_pc,
        input  PC_IF, flush, fifo_full, resolve_err
`ifdef NPC_STATS_EN
        , input stat_pred, stat_mispred
`endif
    );
    modport slave (
        input  stall, is_ctrl_IF, ras_hit, ras_pc, btb_hit, btb_taken, btb_target,
        input  id_redirect, id_target, resolve_valid, resolve_pc,
        output PC_IF, flush, fifo_full, resolve_err
`ifdef NPC_STATS_EN
        , output stat_pred, stat_mispred
`endif
    );
endinterface

// File: rtl/next_pc_gen_pred_fifo.sv
// pred_fifo: in-order prediction record FIFO with clear and youngest-entry rewrite
module pred_fifo import npc_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic                   overwrite_tail,
    input  pred_entry_t            din,
    input  logic [31:0]            ow_next,
    output pred_entry_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    pred_entry_t   mem [DEPTH];
    logic [AW-1:0] wptr, rptr, tail;
    assign tail = wptr - AW'(1);
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rptr];
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // the ID redirect rewrites the record of the jump already queued for it
    always_ff @(posedge CLK) begin
        if (push && !clear) mem[wptr] <= din;
        else if (overwrite_tail && !clear && !empty) begin
            mem[tail].pred_next <= ow_next;
            mem[tail].src       <= SRC_ID;
        end
    end
endmodule

// File: rtl/next_pc_gen.sv
// next_pc_gen: fetch PC select, prediction FIFO check, redirect/flush; NPC_STATS_EN adds counters
module next_pc_gen import npc_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter int          FIFO_DEPTH   = 8
) (
    input logic         CLK,
    input logic         RESET,
    next_pc_gen_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [31:0] pc, pred_next, npc;
    pred_src_t   src;
    pred_entry_t entry, head;
    logic        full, empty, pop, push, mispredict, hold, flush_q, err_q, btb_take;
    logic [CW-1:0] count;
    logic        unused_head;
    always_comb begin
        btb_take   = bus.btb_hit && bus.btb_taken;
        pred_next  = bus.ras_hit ? bus.ras_pc : btb_take ? bus.btb_target : pc + PC_STEP;
        src        = bus.ras_hit ? SRC_RAS : btb_take ? SRC_BTB : SRC_SEQ;
        entry      = '{pc: pc, pred_next: pred_next, src: src};
        pop        = bus.resolve_valid && !empty;
        mispredict = pop && head.pred_next != bus.resolve_pc;
        hold       = bus.stall || (bus.is_ctrl_IF && full && !pop);
        push       = bus.is_ctrl_IF && !bus.stall && !mispredict && !bus.id_redirect && (!full || pop);
        npc        = mispredict ? bus.resolve_pc : bus.id_redirect ? bus.id_target : hold ? pc : pred_next;
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc      <= RESET_VECTOR;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc      <= npc;
            flush_q <= mispredict || bus.id_redirect;
            err_q   <= bus.resolve_valid && empty;
        end
    end
    pred_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK(CLK),
        .RESET(RESET),
        .push(push),
        .pop(pop),
        .clear(mispredict),
        .overwrite_tail(bus.id_redirect),
        .din(entry),
        .ow_next(bus.id_target),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    assign unused_head     = ^{head.pc, head.src, count};
    assign bus.PC_IF       = pc;
    assign bus.flush       = flush_q;
    assign bus.fifo_full   = full;
    assign bus.resolve_err = err_q;
`ifdef NPC_STATS_EN
    logic [31:0] n_pred, n_mis;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            n_pred <= '0;
            n_mis  <= '0;
        end else begin
            if (push && n_pred != '1) n_pred <= n_pred + 32'd1;
            if (mispredict && n_mis != '1) n_mis <= n_mis + 32'd1;
        end
    end
    assign bus.stat_pred    = n_pred;
    assign bus.stat_mispred = n_mis;
`endif
endmodule

// File: tb/tb_next_pc_gen.sv
// tb_next_pc_gen: queue-based reference model plus directed vectors for next_pc_gen
module tb_next_pc_gen;
    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam int DEPTH = 8;
    logic CLK = 1'b0;
    logic RESET;
    int checks = 0;
    int errors = 0;
    next_pc_gen_if bus();
    next_pc_gen #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );
    always #5 CLK = ~CLK;

    logic [31:0] m_pc = RV;
    logic [31:0] q[$];
    logic        m_flush = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_np = '0;
    logic [31:0] m_nm = '0;
    logic [31:0] pn;
    logic        pv, mis;

    // reference: queue of predicted next-PCs, oldest first
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_pc = RV;
            q.delete();
            m_flush = 1'b0;
            m_err = 1'b0;
            m_np = '0;
            m_nm = '0;
        end else begin
            pn = bus.ras_hit ? bus.ras_pc : (bus.btb_hit && bus.btb_taken) ? bus.btb_target : m_pc + 32'd4;
            pv = bus.resolve_valid && q.size() > 0;
            mis = pv && q[0] != bus.resolve_pc;
            m_err = bus.resolve_valid && q.size() == 0;
            m_flush = mis || bus.id_redirect;
            if (mis) begin
                m_pc = bus.resolve_pc;
                q.delete();
                m_nm = m_nm + 1;
            end else begin
                if (pv) void'(q.pop_front());
                if (bus.id_redirect) begin
                    m_pc = bus.id_target;
                    if (q.size() > 0) q[q.size()-1] = bus.id_target;
                end else if (!(bus.stall || (bus.is_ctrl_IF && q.size() == DEPTH && !pv))) begin
                    if (bus.is_ctrl_IF) begin
                        q.push_back(pn);
                        m_np = m_np + 1;
                    end
                    m_pc = pn;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("model_pc", bus.PC_IF, m_pc);
        chk("model_flush", 32'(bus.flush), 32'(m_flush));
        chk("model_err", 32'(bus.resolve_err), 32'(m_err));
        chk("model_full", 32'(bus.fifo_full), 32'(q.size() == DEPTH));
`ifdef NPC_STATS_EN
        chk("model_stat_pred", bus.stat_pred, m_np);
        chk("model_stat_mispred", bus.stat_mispred, m_nm);
`endif
    end

    task automatic idle();
        bus.stall = 0; bus.is_ctrl_IF = 0; bus.ras_hit = 0; bus.ras_pc = '0;
        bus.btb_hit = 0; bus.btb_taken = 0; bus.btb_target = '0;
        bus.id_redirect = 0; bus.id_target = '0; bus.resolve_valid = 0; bus.resolve_pc = '0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc", bus.PC_IF, RV);
        chk("rst_flush", 32'(bus.flush), 0);
        chk("rst_err", 32'(bus.resolve_err), 0);
        chk("rst_full", 32'(bus.fifo_full), 0);
        RESET = 1'b1;
        step(); chk("seq_pc1", bus.PC_IF, 32'hBFC0_0004);
        step(); chk("seq_pc2", bus.PC_IF, 32'hBFC0_0008);
        step(); chk("seq_pc3", bus.PC_IF, 32'hBFC0_000C);
        chk("seq_flush", 32'(bus.flush), 0);
        // BTB taken, then correct resolve
        bus.is_ctrl_IF = 1; bus.btb_hit = 1; bus.btb_taken = 1; bus.btb_target = 32'h0040_0100;
        step(); chk("btb_pc", bus.PC_IF, 32'h0040_0100);
        idle(); bus.resolve_valid = 1; bus.resolve_pc = 32'h0040_0100;
        step(); chk("btb_ok_pc", bus.PC_IF, 32'h0040_0104);
        chk("btb_ok_flush", 32'(bus.flush), 0);
        // RAS prediction, later mispredicted
        idle(); bus.is_ctrl_IF = 1; bus.ras_hit = 1; bus.ras_pc = 32'h0040_0200;
        step(); chk("ras_pc", bus.PC_IF, 32'h0040_0200);
        idle();
        step(); chk("ras_seq_pc", bus.PC_IF, 32'h0040_0204);
        bus.resolve_valid = 1; bus.resolve_pc = 32'h0040_0300;
        step(); chk("mis_pc", bus.PC_IF, 32'h0040_0300);
        chk("mis_flush", 32'(bus.flush), 1);
`ifdef NPC_STATS_EN
        chk("mis_stat", bus.stat_mispred, 1);
`endif
        idle();
        step(); chk("mis_flush_off", 32'(bus.flush), 0);
        chk("mis_after_pc", bus.PC_IF, 32'h0040_0304);
        // fill the FIFO
        bus.is_ctrl_IF = 1;
        for (int i = 0; i < DEPTH; i++) step();
        chk("full_flag", 32'(bus.fifo_full), 1);
        chk("full_pc", bus.PC_IF, 32'h0040_0324);
        step(); chk("full_hold", bus.PC_IF, 32'h0040_0324);
        bus.resolve_valid = 1; bus.resolve_pc = 32'h0040_0308;
        step(); chk("full_pushpop_pc", bus.PC_IF, 32'h0040_0328);
        chk("full_pushpop_flag", 32'(bus.fifo_full), 1);
        // redirect beats stall, mispredict beats redirect
        idle(); bus.stall = 1; bus.id_redirect = 1; bus.id_target = 32'h0040_0400;
        step(); chk("idr_pc", bus.PC_IF, 32'h0040_0400);
        chk("idr_flush", 32'(bus.flush), 1);
        bus.resolve_valid = 1; bus.resolve_pc = 32'h0040_0500;
        step(); chk("mis_over_idr", bus.PC_IF, 32'h0040_0500);
        chk("mis_over_idr_full", 32'(bus.fifo_full), 0);
        idle();
        step(); chk("after_clear_pc", bus.PC_IF, 32'h0040_0504);
`ifdef NPC_STATS_EN
        chk("stat_pred_total", bus.stat_pred, 11);
        chk("stat_mis_total", bus.stat_mispred, 2);
`endif
        // resolve with empty FIFO
        bus.resolve_valid = 1; bus.resolve_pc = 32'h1234_5678;
        step(); chk("err_pulse", 32'(bus.resolve_err), 1);
        chk("err_pc", bus.PC_IF, 32'h0040_0508);
        idle();
        step(); chk("err_clear", 32'(bus.resolve_err), 0);
        chk("err_pc2", bus.PC_IF, 32'h0040_050C);
        // asynchronous reset mid-operation
        RESET = 1'b0;
        #1;
        chk("async_rst_pc", bus.PC_IF, RV);
        step();
        RESET = 1'b1;
        step(); chk("rst_release_pc", bus.PC_IF, 32'hBFC0_0004);
`ifdef NPC_STATS_EN
        chk("rst_stat", bus.stat_pred, 0);
`endif
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
